// File: rtl/dma_rx_pkt_fifo.sv
// dma_rx_pkt_fifo: store-and-forward packet FIFO ahead of the DMA slave stream.
// A packet is released to m_axis only after its last beat is buffered; packets
// that do not fit are dropped whole and the input never back-pressures.
// Optional statistics counters: define DMA_RX_PKT_FIFO_STATS_EN.
module dma_rx_pkt_fifo #(
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEPTH_LOG2       = 9,
  parameter int C_PKTS_LOG2        = 5
) (
  input  logic                            axi_aclk,
  input  logic                            axi_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic                            drop_pulse
`ifdef DMA_RX_PKT_FIFO_STATS_EN
  ,
  output logic [31:0]                     pkt_in_count,
  output logic [31:0]                     pkt_drop_count,
  output logic [31:0]                     pkt_out_count
`endif
);
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int DD = 2 ** C_DEPTH_LOG2;
  localparam int PD = 2 ** C_PKTS_LOG2;
  localparam int PW = C_DEPTH_LOG2 + 1;  // data pointers / packet length
  localparam int MW = C_PKTS_LOG2 + 1;   // metadata pointers

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_DISCARD} wstate_e;

  wstate_e         state_q, state_d;
  logic [PW-1:0]   ws_q, ws_d, wc_q, wc_d, rd_q, rf_q, fcnt_q;
  logic [UW-1:0]   tuser_q, tuser_d, push_user;
  logic [MW-1:0]   mw_q, mr_q, mf_q;
  logic            rdy_q, drop_q;
  logic            beat_in, data_full, meta_full, mem_we, meta_push, drop;
  logic [PW-1:0]   push_len;

  logic [SW+DW-1:0] dmem [DD];
  logic [UW-1:0]    muser [PD];
  logic [PW-1:0]    mlen [PD];
  logic [SW+DW-1:0] rdata_q;

  // read pipeline: stage 1 = RAM read register, stage 2 = output register
  logic            v1_q, last1_q, v2_q, last2_q;
  logic [UW-1:0]   user1_q, user2_q;
  logic [DW-1:0]   data2_q;
  logic [SW-1:0]   strb2_q;
  logic            adv2, fetch, fetch_last, hs, pop;

  assign beat_in   = s_axis_tvalid && rdy_q;
  // rd only advances on output handshakes, so prefetched beats still count as occupied
  assign data_full = (ws_q - rd_q) == PW'(DD);
  assign meta_full = (mw_q - mr_q) == MW'(PD);
  assign push_len  = ws_q + PW'(1) - wc_q;

  // write FSM: stores, commits or discards the incoming packet
  always_comb begin
    state_d   = state_q;
    ws_d      = ws_q;
    wc_d      = wc_q;
    tuser_d   = tuser_q;
    push_user = tuser_q;
    mem_we    = 1'b0;
    meta_push = 1'b0;
    drop      = 1'b0;
    if (beat_in) begin
      case (state_q)
        W_IDLE: begin
          // in IDLE ws==wc, so a full data store also means the packet cannot start
          if (meta_full || data_full) begin
            if (s_axis_tlast) drop = 1'b1;
            else              state_d = W_DISCARD;
          end else begin
            mem_we    = 1'b1;
            ws_d      = ws_q + PW'(1);
            tuser_d   = s_axis_tuser;
            push_user = s_axis_tuser;
            if (s_axis_tlast) begin
              wc_d      = ws_q + PW'(1);
              meta_push = 1'b1;
            end else begin
              state_d = W_STORE;
            end
          end
        end
        W_STORE: begin
          if (data_full) begin
            ws_d = wc_q;
            if (s_axis_tlast) begin
              drop    = 1'b1;
              state_d = W_IDLE;
            end else begin
              state_d = W_DISCARD;
            end
          end else begin
            mem_we = 1'b1;
            ws_d   = ws_q + PW'(1);
            if (s_axis_tlast) begin
              wc_d      = ws_q + PW'(1);
              meta_push = 1'b1;
              state_d   = W_IDLE;
            end
          end
        end
        W_DISCARD: begin
          if (s_axis_tlast) begin
            drop    = 1'b1;
            state_d = W_IDLE;
          end
        end
        default: state_d = W_IDLE;
      endcase
    end
  end

  // write-side state and pointers
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= W_IDLE;
      ws_q    <= '0;
      wc_q    <= '0;
      tuser_q <= '0;
      rdy_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_d;
      wc_q    <= wc_d;
      tuser_q <= tuser_d;
      rdy_q   <= 1'b1;
      drop_q  <= drop;
    end
  end

  // storage arrays (no reset so they map onto block/distributed RAM)
  always_ff @(posedge axi_aclk) begin
    if (mem_we)    dmem[ws_q[C_DEPTH_LOG2-1:0]] <= {s_axis_tstrb, s_axis_tdata};
    if (fetch)     rdata_q <= dmem[rf_q[C_DEPTH_LOG2-1:0]];
    if (meta_push) begin
      muser[mw_q[C_PKTS_LOG2-1:0]] <= push_user;
      mlen[mw_q[C_PKTS_LOG2-1:0]]  <= push_len;
    end
  end

  assign adv2       = !v2_q || m_axis_tready;
  assign fetch      = (mf_q != mw_q) && (!v1_q || adv2);
  assign fetch_last = (fcnt_q + PW'(1)) == mlen[mf_q[C_PKTS_LOG2-1:0]];
  assign hs         = v2_q && m_axis_tready;
  assign pop        = hs && last2_q;

  // fetch side: walks committed packets and feeds the RAM read stage
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      mw_q    <= '0;
      mr_q    <= '0;
      mf_q    <= '0;
      rf_q    <= '0;
      rd_q    <= '0;
      fcnt_q  <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      user1_q <= '0;
    end else begin
      if (meta_push) mw_q <= mw_q + MW'(1);
      if (pop)       mr_q <= mr_q + MW'(1);
      if (hs)        rd_q <= rd_q + PW'(1);
      if (fetch) begin
        v1_q    <= 1'b1;
        user1_q <= muser[mf_q[C_PKTS_LOG2-1:0]];
        last1_q <= fetch_last;
        rf_q    <= rf_q + PW'(1);
        if (fetch_last) begin
          mf_q   <= mf_q + MW'(1);
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + PW'(1);
        end
      end else if (v1_q && adv2) begin
        v1_q <= 1'b0;
      end
    end
  end

  // output register: holds steady while the DMA stalls
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      data2_q <= '0;
      strb2_q <= '0;
      user2_q <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        data2_q <= rdata_q[DW-1:0];
        strb2_q <= rdata_q[SW+DW-1:DW];
        user2_q <= user1_q;
        last2_q <= last1_q;
      end
    end
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = v2_q;
  assign m_axis_tdata  = data2_q;
  assign m_axis_tstrb  = strb2_q;
  assign m_axis_tuser  = user2_q;
  assign m_axis_tlast  = last2_q;
  assign drop_pulse    = drop_q;

`ifdef DMA_RX_PKT_FIFO_STATS_EN
  logic [31:0] in_cnt_q, drop_cnt_q, out_cnt_q;

  // packet statistics, free-running and wrapping
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      in_cnt_q   <= '0;
      drop_cnt_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      if (meta_push) in_cnt_q   <= in_cnt_q + 32'd1;
      if (drop)      drop_cnt_q <= drop_cnt_q + 32'd1;
      if (pop)       out_cnt_q  <= out_cnt_q + 32'd1;
    end
  end

  assign pkt_in_count   = in_cnt_q;
  assign pkt_drop_count = drop_cnt_q;
  assign pkt_out_count  = out_cnt_q;
`endif

endmodule

// File: tb/tb_dma_rx_pkt_fifo.sv
// Scoreboard bench for dma_rx_pkt_fifo: expected beats are queued as stimulus
// is driven and compared against beats collected from m_axis.
module tb_dma_rx_pkt_fifo;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int UW = 128;

  logic          axi_aclk = 1'b0;
  logic          axi_resetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [SW-1:0] s_axis_tstrb = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          drop_pulse;
`ifdef DMA_RX_PKT_FIFO_STATS_EN
  logic [31:0]   pkt_in_count, pkt_drop_count, pkt_out_count;
`endif

  dma_rx_pkt_fifo dut (
    .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .drop_pulse(drop_pulse)
`ifdef DMA_RX_PKT_FIFO_STATS_EN
    , .pkt_in_count(pkt_in_count), .pkt_drop_count(pkt_drop_count), .pkt_out_count(pkt_out_count)
`endif
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct packed {
    logic  v;
    logic  r;
    logic  dp;
    beat_t b;
  } smp_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  smp_t  hist_q[$];
  int    drop_cnt = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    tog_en = 1'b0;

  // one clock: sample outputs mid-cycle, then let the edge pass
  task automatic tick();
    smp_t s;
    @(negedge axi_aclk);
    s.v  = m_axis_tvalid;
    s.r  = m_axis_tready;
    s.dp = drop_pulse;
    s.b  = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
    hist_q.push_back(s);
    if (m_axis_tvalid && m_axis_tready) got_q.push_back(s.b);
    if (drop_pulse) drop_cnt++;
    @(posedge axi_aclk);
    #1;
    if (tog_en) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic send_pkt(input int len, input logic [UW-1:0] user, input int tag, input bit pass);
    beat_t e;
    for (int i = 0; i < len; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {tag, i};
      s_axis_tstrb  = 8'(i * 37 + tag);
      s_axis_tuser  = (i == 0) ? user : ~user;
      s_axis_tlast  = (i == len - 1);
      if (pass) begin
        e = {s_axis_tdata, s_axis_tstrb, user, s_axis_tlast};
        exp_q.push_back(e);
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 3000 && got_q.size() < n; k++) tick();
    repeat (8) tick();
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    axi_resetn    = 1'b0;
    repeat (3) @(posedge axi_aclk);
    #1 axi_resetn = 1'b1;
    @(posedge axi_aclk);
    #1;
    exp_q.delete(); got_q.delete(); hist_q.delete();
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (s_axis_tready !== 1'b0 || drop_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_in: tready=%b drop=%b required 0 0", s_axis_tready, drop_pulse);
    end
    n_checks++;
    if ({m_axis_tvalid, m_axis_tlast} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ctl: tvalid=%b tlast=%b required 0 0", m_axis_tvalid, m_axis_tlast);
    end
    n_checks++;
    if ({m_axis_tdata, m_axis_tstrb, m_axis_tuser} !== '0) begin
      n_fail++; $display("FAIL reset_data: data=%h strb=%h user=%h required 0", m_axis_tdata, m_axis_tstrb, m_axis_tuser);
    end
    repeat (3) @(posedge axi_aclk);
    #1 axi_resetn = 1'b1;
    #1;
    n_checks++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy_early: tready=%b required 0", s_axis_tready);
    end
    @(posedge axi_aclk);
    #1;
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++; $display("FAIL reset_rdy: tready=%b required 1", s_axis_tready);
    end
  endtask

  task automatic test_single();
    int seen = 0;
    m_axis_tready = 1'b1;
    hist_q.delete();
    send_pkt(8, 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5, 1, 1'b1);
    foreach (hist_q[k]) if (hist_q[k].v) seen++;
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL single_early_valid: %0d valid samples, required 0", seen);
    end
    hist_q.delete();
    repeat (3) tick();
    n_checks++;
    if ({hist_q[0].v, hist_q[1].v, hist_q[2].v} !== 3'b001) begin
      n_fail++; $display("FAIL single_latency: valid after N,N+1,N+2 = %b%b%b required 001",
                         hist_q[0].v, hist_q[1].v, hist_q[2].v);
    end
    drain(8);
    n_checks++;
    if (got_q.size() !== 8) begin
      n_fail++; $display("FAIL single_count: got %0d beats, required 8", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      beat_t g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL single_beat: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_oversize();
    int d0 = drop_cnt;
    m_axis_tready = 1'b1;
    hist_q.delete();
    send_pkt(600, 128'h11, 2, 1'b0);
    send_pkt(4, 128'h22, 3, 1'b1);
    drain(4);
    n_checks++;
    if (drop_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL oversize_drops: %0d pulses, required 1", drop_cnt - d0);
    end
    n_checks++;
    if (hist_q[600].dp !== 1'b1) begin
      n_fail++; $display("FAIL oversize_pulse_time: drop after beat 600 = %b required 1", hist_q[600].dp);
    end
    n_checks++;
    if (got_q.size() !== 4) begin
      n_fail++; $display("FAIL oversize_count: got %0d beats, required 4", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      beat_t g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL oversize_beat: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_meta_full();
    int d0 = drop_cnt;
    m_axis_tready = 1'b0;
    for (int p = 0; p < 33; p++) send_pkt(1, 128'(p * 7 + 3), 100 + p, p < 32);
    repeat (4) tick();
    n_checks++;
    if (drop_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL meta_full_drops: %0d pulses, required 1", drop_cnt - d0);
    end
    m_axis_tready = 1'b1;
    drain(32);
    n_checks++;
    if (got_q.size() !== 32) begin
      n_fail++; $display("FAIL meta_full_count: got %0d packets, required 32", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      beat_t g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL meta_full_beat: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    int first;
    int run;
    // stalled output: tready toggles every cycle
    hist_q.delete();
    m_axis_tready = 1'b1;
    tog_en = 1'b1;
    for (int p = 0; p < 3; p++) send_pkt(5, 128'(200 + p), 200 + p, 1'b1);
    drain(15);
    tog_en = 1'b0;
    m_axis_tready = 1'b1;
    for (int k = 1; k < hist_q.size(); k++) begin
      if (hist_q[k-1].v && !hist_q[k-1].r) begin
        n_checks++;
        if (!hist_q[k].v || hist_q[k].b !== hist_q[k-1].b) begin
          n_fail++; $display("FAIL bp_stable: v=%b beat %h required %h", hist_q[k].v, hist_q[k].b, hist_q[k-1].b);
        end
      end
    end
    n_checks++;
    if (got_q.size() !== 15) begin
      n_fail++; $display("FAIL bp_count: got %0d beats, required 15", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      beat_t g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL bp_beat: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    // free-flowing output: 15 beats must be contiguous
    hist_q.delete();
    for (int p = 0; p < 3; p++) send_pkt(5, 128'(300 + p), 300 + p, 1'b1);
    drain(15);
    first = -1;
    run = 0;
    foreach (hist_q[k]) if (first < 0 && hist_q[k].v) first = k;
    if (first >= 0)
      for (int k = first; k < first + 15 && k < hist_q.size(); k++) if (hist_q[k].v) run++;
    n_checks++;
    if (run !== 15) begin
      n_fail++; $display("FAIL b2b_contiguous: %0d valid of 15 consecutive cycles, required 15", run);
    end
    n_checks++;
    if (got_q.size() !== 15) begin
      n_fail++; $display("FAIL b2b_count: got %0d beats, required 15", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      beat_t g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL b2b_beat: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    int d0;
    m_axis_tready = 1'b0;
    send_pkt(2, 128'h77, 50, 1'b0);
    repeat (4) tick();
    n_checks++;
    if (m_axis_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pending: tvalid=%b required 1", m_axis_tvalid);
    end
    for (int i = 0; i < 3; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {32'd51, i};
      s_axis_tuser  = 128'h88;
      s_axis_tlast  = 1'b0;
      if (i < 2) tick();
    end
    axi_resetn = 1'b0;
    #1;
    n_checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, drop_pulse} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_ctl: tready=%b tvalid=%b tlast=%b drop=%b required 0",
                         s_axis_tready, m_axis_tvalid, m_axis_tlast, drop_pulse);
    end
    n_checks++;
    if ({m_axis_tdata, m_axis_tstrb, m_axis_tuser} !== '0) begin
      n_fail++; $display("FAIL rstmid_data: data=%h user=%h required 0", m_axis_tdata, m_axis_tuser);
    end
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge axi_aclk);
    #1 axi_resetn = 1'b1;
    @(posedge axi_aclk);
    #1;
    exp_q.delete(); got_q.delete();
    d0 = drop_cnt;
    m_axis_tready = 1'b1;
    send_pkt(2, 128'h99, 60, 1'b1);
    drain(2);
    n_checks++;
    if (got_q.size() !== 2) begin
      n_fail++; $display("FAIL rstmid_count: got %0d beats, required 2", got_q.size());
    end
    n_checks++;
    if (drop_cnt !== d0) begin
      n_fail++; $display("FAIL rstmid_drops: %0d pulses, required 0", drop_cnt - d0);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      beat_t e = exp_q.pop_front();
      beat_t g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL rstmid_beat: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

`ifdef DMA_RX_PKT_FIFO_STATS_EN
  task automatic test_stats();
    do_reset();
    n_checks++;
    if ({pkt_in_count, pkt_drop_count, pkt_out_count} !== '0) begin
      n_fail++; $display("FAIL stats_reset: in=%0d drop=%0d out=%0d required 0", pkt_in_count, pkt_drop_count, pkt_out_count);
    end
    m_axis_tready = 1'b1;
    send_pkt(600, 128'h1, 70, 1'b0);
    send_pkt(4, 128'h2, 71, 1'b1);
    send_pkt(3, 128'h3, 72, 1'b1);
    send_pkt(2, 128'h4, 73, 1'b1);
    drain(9);
    n_checks++;
    if (pkt_in_count !== 32'd3) begin n_fail++; $display("FAIL stats_in: %0d required 3", pkt_in_count); end
    n_checks++;
    if (pkt_drop_count !== 32'd1) begin n_fail++; $display("FAIL stats_drop: %0d required 1", pkt_drop_count); end
    n_checks++;
    if (pkt_out_count !== 32'd3) begin n_fail++; $display("FAIL stats_out: %0d required 3", pkt_out_count); end
    exp_q.delete(); got_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_oversize();
    test_meta_full();
    test_back_to_back();
    test_reset_mid();
`ifdef DMA_RX_PKT_FIFO_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
